crossbar_ctrl_sequencer: RTL and testbench

//  Upstream control stage for the 4x4 4-bit crossbar. Holds a small table of 5-bit

---
 rtl/crossbar_defs_pkg.sv | 16 +
 rtl/crossbar_ctrl_table.sv | 22 ++
 rtl/crossbar_ctrl_sequencer.sv | 153 +++++++++++++++
 tb/tb_crossbar_ctrl_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_defs_pkg.sv
// Shared definitions for the crossbar control sequencer: widths, table geometry, FSM states.
// Optional looped playback is enabled by defining CTRL_SEQ_LOOP_EN.
package crossbar_defs;
    localparam int CTRL_W  = 5;
    localparam int HOLD_W  = 4;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int LEN_W   = ADDR_W + 1;
    localparam int ENTRY_W = CTRL_W + HOLD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/crossbar_ctrl_table.sv
// Control-word table: one synchronous write port, one combinational read port, no reset.
module crossbar_ctrl_table #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 9
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_data
);
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/crossbar_ctrl_sequencer.sv
// Plays a table of crossbar control words with per-entry dwell times via start/busy/done.
// Define CTRL_SEQ_LOOP_EN to add the `loop` input for continuous wrap-around playback.
module crossbar_ctrl_sequencer
    import crossbar_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
`ifdef CTRL_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [CTRL_W-1:0] control,
    output logic              ctrl_valid,
    output logic [ADDR_W-1:0] entry_idx,
    output logic              busy,
    output logic              done
);
    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [ADDR_W-1:0]   last_reg, last_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [CTRL_W-1:0]   control_reg, control_next;
    logic                valid_reg, valid_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic [ADDR_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0]  rd_data, entry;
    logic [LEN_W-1:0]    len_clamped;
    logic                table_we;
    logic                wrap;

    assign table_we = wr_en && (state_reg == ST_IDLE);

    crossbar_ctrl_table #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (table_we),
        .wr_addr (wr_addr),
        .wr_data ({wr_ctrl, wr_hold}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // A write landing on the same edge as start must be seen by the first played word.
    assign entry = (table_we && (wr_addr == rd_addr)) ? {wr_ctrl, wr_hold} : rd_data;

    assign len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;

`ifdef CTRL_SEQ_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        hold_next    = hold_reg;
        control_next = control_reg;
        valid_next   = valid_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        rd_addr      = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_next   = ST_RUN;
                    idx_next     = '0;
                    last_next    = ADDR_W'(len_clamped - LEN_W'(1));
                    control_next = entry[ENTRY_W-1:HOLD_W];
                    hold_next    = entry[HOLD_W-1:0];
                    valid_next   = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    idx_next     = '0;
                    hold_next    = '0;
                    control_next = '0;
                    valid_next   = 1'b0;
                    busy_next    = 1'b0;
                end else if (hold_reg != '0) begin
                    hold_next = hold_reg - HOLD_W'(1);
                end else if ((idx_reg != last_reg) || wrap) begin
                    // Next entry (or wrap to entry 0) loads with no gap cycle.
                    rd_addr      = (idx_reg != last_reg) ? idx_reg + ADDR_W'(1) : '0;
                    idx_next     = rd_addr;
                    control_next = entry[ENTRY_W-1:HOLD_W];
                    hold_next    = entry[HOLD_W-1:0];
                end else begin
                    state_next   = ST_DONE;
                    idx_next     = '0;
                    control_next = '0;
                    valid_next   = 1'b0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_IDLE;
                idx_next     = '0;
                hold_next    = '0;
                control_next = '0;
                valid_next   = 1'b0;
                busy_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            last_reg    <= '0;
            hold_reg    <= '0;
            control_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            hold_reg    <= hold_next;
            control_reg <= control_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign control    = control_reg;
    assign ctrl_valid = valid_reg;
    assign entry_idx  = idx_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
endmodule

// File: tb/tb_crossbar_ctrl_sequencer.sv
// Scoreboard bench for crossbar_ctrl_sequencer: expected per-cycle outputs are queued
// from a bench-side table model when playback is started, then popped each cycle.
module tb_crossbar_ctrl_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_ctrl = '0;
    logic [3:0] wr_hold = '0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic       abort = 1'b0;
`ifdef CTRL_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif
    logic [4:0] control;
    logic       ctrl_valid;
    logic [2:0] entry_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] ctrl;
        logic       valid;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb_q[$];
    logic [4:0] m_ctrl [8];
    logic [3:0] m_hold [8];

    always #5 clk = ~clk;

    crossbar_ctrl_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_ctrl    (wr_ctrl),
        .wr_hold    (wr_hold),
        .start      (start),
        .len        (len),
        .abort      (abort),
`ifdef CTRL_SEQ_LOOP_EN
        .loop       (loop),
`endif
        .control    (control),
        .ctrl_valid (ctrl_valid),
        .entry_idx  (entry_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_control"}, 32'(control), 32'd0);
        check({tag, "_valid"}, 32'(ctrl_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic wr(input int addr, input logic [4:0] c, input logic [3:0] h);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_ctrl = c; wr_hold = h;
        @(negedge clk);
        wr_en = 1'b0;
        m_ctrl[addr] = c;
        m_hold[addr] = h;
    endtask

    // Builds the expected trace, starts playback, and compares every cycle.
    // abort_at: cycle after start (1-based) during which abort is held; 0 = none.
    // junk_wr:  hammer entry 1 with writes throughout playback (must be dropped).
    task automatic play(input string tag, input int n_len, input int abort_at,
                        input bit junk_wr, input bit wr0_with_start, input logic [4:0] c0);
        int n, k, cyc;
        bit stop;
        exp_t e;
        @(negedge clk);
        if (wr0_with_start) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_ctrl = c0; wr_hold = m_hold[0];
            m_ctrl[0] = c0;
        end
        n = (n_len > 8) ? 8 : n_len;
        k = 0;
        stop = 1'b0;
        sb_q.delete();
        for (int ent = 0; ent < n && !stop; ent++) begin
            for (int h = 0; h <= int'(m_hold[ent]); h++) begin
                k++;
                if (abort_at != 0 && k > abort_at) begin
                    stop = 1'b1;
                    break;
                end
                sb_q.push_back('{ctrl: m_ctrl[ent], valid: 1'b1, idx: 3'(ent), busy: 1'b1, done: 1'b0});
            end
        end
        sb_q.push_back('{ctrl: 5'd0, valid: 1'b0, idx: 3'd0, busy: 1'b0, done: !stop});
        sb_q.push_back('{ctrl: 5'd0, valid: 1'b0, idx: 3'd0, busy: 1'b0, done: 1'b0});
        start = 1'b1;
        len = 4'(n_len);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        cyc = 0;
        while (sb_q.size() != 0) begin
            cyc++;
            e = sb_q.pop_front();
            check($sformatf("%s_c%0d_control", tag, cyc), 32'(control), 32'(e.ctrl));
            check($sformatf("%s_c%0d_valid", tag, cyc), 32'(ctrl_valid), 32'(e.valid));
            check($sformatf("%s_c%0d_busy", tag, cyc), 32'(busy), 32'(e.busy));
            check($sformatf("%s_c%0d_done", tag, cyc), 32'(done), 32'(e.done));
            if (e.valid) check($sformatf("%s_c%0d_idx", tag, cyc), 32'(entry_idx), 32'(e.idx));
            $display("TXN %s cycle=%0d control=%b valid=%b busy=%b done=%b", tag, cyc,
                     control, ctrl_valid, busy, done);
            abort = (cyc == abort_at);
            start = busy;  // start while busy must be ignored
            if (junk_wr && busy) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_ctrl = 5'b01110; wr_hold = 4'd7;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check_idle("reset_hold");
        check("reset_idx", 32'(entry_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        wr(0, 5'b00001, 4'd0);
        wr(1, 5'b10101, 4'd1);
        wr(2, 5'b11111, 4'd2);

        play("basic", 3, 0, 1'b0, 1'b0, 5'd0);
        play("abort", 3, 3, 1'b0, 1'b0, 5'd0);
        play("junkwr", 3, 0, 1'b1, 1'b0, 5'd0);
        play("old_t1", 3, 0, 1'b0, 1'b0, 5'd0);

        // start with len==0 stays idle
        @(negedge clk);
        start = 1'b1; len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        check_idle("len0_a");
        @(negedge clk);
        check_idle("len0_b");

        // Same-cycle write to entry 0 with start
        play("wr0_start", 2, 0, 1'b0, 1'b1, 5'b01010);

        // All 8 entries hold=0, len clamped from 15 to 8
        for (int i = 0; i < 8; i++) wr(i, 5'($urandom_range(1, 31)), 4'd0);
        play("clamp", 15, 0, 1'b0, 1'b0, 5'd0);

        // Maximum dwell on one entry
        wr(0, 5'b10011, 4'd15);
        play("maxhold", 1, 0, 1'b0, 1'b0, 5'd0);

        // Asynchronous reset in the middle of playback
        @(negedge clk);
        start = 1'b1; len = 4'd8;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_idx", 32'(entry_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=hang expected=finish");
        $fatal(1, "timeout");
    end
endmodule
